// File: rtl/output_display_driver_if.sv
// Bus-side signal bundle for the output register / display driver.
// The master drives the bus and load strobe; the slave is the display driver.
interface output_display_driver_if;
    logic [7:0] bus;
    logic       load;
    logic       signed_mode;
    logic [7:0] value;
    logic       busy;
    logic [3:0] digit_en;
    logic [6:0] seg;

    modport master (
        output bus, load, signed_mode,
        input  value, busy, digit_en, seg
    );

    modport slave (
        input  bus, load, signed_mode,
        output value, busy, digit_en, seg
    );
endinterface

// File: rtl/output_display_driver.sv
// Output register of the 8-bit computer: captures the bus on load, converts it to
// decimal with a serial double-dabble, and scans a 4-digit 7-segment display.
module output_display_driver #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output_display_driver_if.slave dif
);
    localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {S_IDLE, S_CONVERT} state_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    state_e         state_q, state_d;
    logic [7:0]     value_q, value_d;
    logic           neg_q, neg_d;
    logic [7:0]     shift_q, shift_d;
    logic [11:0]    bcd_q, bcd_d;
    logic [2:0]     iter_q, iter_d;
    logic [6:0]     disp_q [4];
    logic [6:0]     disp_d [4];
    logic [CW-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]     scan_idx_q, scan_idx_d;

    logic [11:0]    bcd_adj;
    logic [11:0]    bcd_step;
    logic [7:0]     shift_step;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h3F;
            4'd1:    seg_code = 7'h06;
            4'd2:    seg_code = 7'h5B;
            4'd3:    seg_code = 7'h4F;
            4'd4:    seg_code = 7'h66;
            4'd5:    seg_code = 7'h6D;
            4'd6:    seg_code = 7'h7D;
            4'd7:    seg_code = 7'h07;
            4'd8:    seg_code = 7'h7F;
            4'd9:    seg_code = 7'h6F;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        value_d    = value_q;
        neg_d      = neg_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        iter_d     = iter_q;
        disp_d     = disp_q;
        scan_cnt_d = scan_cnt_q;
        scan_idx_d = scan_idx_q;

        // One double-dabble step: correct BCD nibbles >= 5, then shift the magnitude in.
        bcd_adj = bcd_q;
        for (int n = 0; n < 3; n++) begin
            if (bcd_q[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
        end
        {bcd_step, shift_step} = {bcd_adj, shift_q} << 1;

        if (state_q == S_CONVERT) begin
            shift_d = shift_step;
            bcd_d   = bcd_step;
            iter_d  = iter_q + 3'd1;
            if (iter_q == 3'd7) begin
                state_d   = S_IDLE;
                disp_d[3] = neg_q ? SEG_MINUS : SEG_BLANK;
                disp_d[2] = (bcd_step[11:8] == 4'd0) ? SEG_BLANK : seg_code(bcd_step[11:8]);
                disp_d[1] = (bcd_step[11:4] == 8'd0) ? SEG_BLANK : seg_code(bcd_step[7:4]);
                disp_d[0] = seg_code(bcd_step[3:0]);
            end
        end

        // A load always (re)starts a conversion, even mid-conversion.
        if (dif.load) begin
            state_d = S_CONVERT;
            value_d = dif.bus;
            neg_d   = dif.signed_mode & dif.bus[7];
            shift_d = (dif.signed_mode & dif.bus[7]) ? 8'(~dif.bus + 8'd1) : dif.bus;
            bcd_d   = '0;
            iter_d  = '0;
        end

        if (scan_cnt_q == CW'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            scan_idx_d = scan_idx_q + 2'd1;
        end else begin
            scan_cnt_d = scan_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            value_q    <= '0;
            neg_q      <= 1'b0;
            shift_q    <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            // NOTE: the four display registers are ordinary flops that must show "0" out of reset, so they are reset explicitly.
            disp_q[3]  <= SEG_BLANK;
            disp_q[2]  <= SEG_BLANK;
            disp_q[1]  <= SEG_BLANK;
            disp_q[0]  <= 7'h3F;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            value_q    <= value_d;
            neg_q      <= neg_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            iter_q     <= iter_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            disp_q     <= disp_d;
        end
    end

    assign dif.value    = value_q;
    assign dif.busy     = (state_q == S_CONVERT);
    assign dif.digit_en = 4'b0001 << scan_idx_q;
    assign dif.seg      = disp_q[scan_idx_q];
endmodule
